// File: rtl/alu_pkg.sv
// Shared definitions for the ALU program sequencer: opcode map, program-word
// layout and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_IDLE = 4'hF;

  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int OPD_MSB = 7;
  localparam int WORD_W  = OPC_MSB + 1;

  typedef logic [WORD_W-1:0] prog_word_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [3:0] word_opc(input prog_word_t w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [7:0] word_opd(input prog_word_t w);
    return w[OPD_MSB:0];
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Host and ALU signals of the sequencer; slave is the sequencer's view,
// master is the surrounding host/ALU side.
interface alu_sequencer_if #(
  parameter int AW = 4
);
  import alu_pkg::*;

  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  prog_word_t       prog_data;
  logic             start;
  logic [AW:0]      len;
  logic             busy;
  logic             done;
  logic [AW-1:0]    pc;
  logic [3:0]       alu_opcode;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [7:0]       result;
  logic             result_valid;

  modport master (
    output prog_we, prog_addr, prog_data, start, len, alu_b,
    input  busy, done, pc, alu_opcode, alu_a, result, result_valid
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, len, alu_b,
    output busy, done, pc, alu_opcode, alu_a, result, result_valid
  );

endinterface

// File: rtl/alu_prog_mem.sv
// Program store: register file with a synchronous write port and an
// asynchronous read port. Contents survive reset.
module alu_prog_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  prog_word_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output prog_word_t    rdata_o
);

  prog_word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Streams {opcode, operand} words from the program store to the ALU, one word
// per STEP_CYCLES window, then drains and captures the accumulator.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int         PROG_DEPTH   = 16,
  parameter int         AW           = 4,
  parameter int         STEP_CYCLES  = 2,
  parameter int         DRAIN_CYCLES = 1,
  parameter logic [3:0] IDLE_OP      = OP_IDLE
) (
  input logic           clk,
  input logic           rst,
  alu_sequencer_if.slave bus
);

  localparam int CMAX = (STEP_CYCLES > DRAIN_CYCLES) ? STEP_CYCLES : DRAIN_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] step_q, step_d;
  logic [AW:0]   len_q, len_d;
  logic          done_q, done_d;
  logic [3:0]    opc_q, opc_d;
  logic [7:0]    opd_q, opd_d;
  logic [7:0]    result_q, result_d;
  logic          rvalid_q, rvalid_d;

  logic          mem_we;
  prog_word_t    rd_word;
  prog_word_t    fetch_word;
  logic          last_instr;

  assign mem_we = bus.prog_we && (state_q == ST_IDLE);

  alu_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (bus.prog_addr),
    .wdata_i (bus.prog_data),
    .raddr_i (pc_d),
    .rdata_o (rd_word)
  );

  // A word written on the start edge must reach the ALU in the first RUN cycle.
  assign fetch_word = (mem_we && (bus.prog_addr == pc_d)) ? bus.prog_data : rd_word;
  assign last_instr = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    step_d   = step_q;
    len_d    = len_q;
    done_d   = 1'b0;
    result_d = result_q;
    rvalid_d = rvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            len_d    = bus.len;
            pc_d     = '0;
            step_d   = '0;
            rvalid_d = 1'b0;
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (last_instr) state_d = ST_DRAIN;
          else            pc_d    = pc_q + AW'(1);
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (step_q == DRAIN_LAST) begin
          step_d   = '0;
          result_d = bus.alu_b;
          rvalid_d = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RUN) begin
      opc_d = word_opc(fetch_word);
      opd_d = word_opd(fetch_word);
    end else begin
      opc_d = IDLE_OP;
      opd_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      step_q   <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
      opc_q    <= IDLE_OP;
      opd_q    <= 8'h00;
      result_q <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      step_q   <= step_d;
      len_q    <= len_d;
      done_q   <= done_d;
      opc_q    <= opc_d;
      opd_q    <= opd_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = done_q;
  assign bus.pc           = pc_q;
  assign bus.alu_opcode   = opc_q;
  assign bus.alu_a        = opd_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rvalid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural accumulator ALU that
// executes each instruction once, on the first edge it is presented.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  alu_sequencer_if #(.AW(AW)) bus ();

  alu_sequencer #(
    .PROG_DEPTH   (16),
    .AW           (AW),
    .STEP_CYCLES  (2),
    .DRAIN_CYCLES (1),
    .IDLE_OP      (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]    acc       = 8'h00;
  logic [AW-1:0] prev_pc   = '0;
  logic          prev_idle = 1'b1;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] ac, input logic [7:0] a);
    case (op)
      OP_LOAD: return a;
      OP_ADD:  return ac + a;
      OP_SUB:  return ac - a;
      OP_AND:  return ac & a;
      OP_OR:   return ac | a;
      OP_XOR:  return ac ^ a;
      default: return ac;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.alu_opcode != OP_IDLE && (prev_idle || bus.pc != prev_pc))
      acc <= alu_f(bus.alu_opcode, acc, bus.alu_a);
    prev_pc   <= bus.pc;
    prev_idle <= (bus.alu_opcode == OP_IDLE);
  end

  assign bus.alu_b = acc;

  typedef struct {
    string      name;
    int         nw;
    prog_word_t prog [16];
    int         len;
    logic [7:0] res;
    int         lat;
  } vec_t;

  vec_t          vecs [6];
  logic [AW-1:0] pc_trace [$];

  function automatic prog_word_t w(input logic [3:0] op, input logic [7:0] d);
    return {op, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input prog_word_t d);
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    @(posedge clk); #1;
    bus.prog_we = 1'b0;
  endtask

  // lat is the cycle index (start cycle = 0) in which done is first high.
  task automatic run_prog(input logic [AW:0] l, input logic we, input logic [AW-1:0] wa,
                          input prog_word_t wd, output int lat, output int busy_cyc,
                          output logic done_after);
    @(negedge clk);
    bus.start = 1'b1; bus.len = l;
    bus.prog_we = we; bus.prog_addr = wa; bus.prog_data = wd;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.prog_we = 1'b0;
    lat = 0; busy_cyc = 0;
    pc_trace.delete();
    for (int c = 1; c <= 200; c++) begin
      if (bus.busy) busy_cyc++;
      if (bus.busy && bus.alu_opcode != OP_IDLE) pc_trace.push_back(bus.pc);
      if (bus.done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    done_after = bus.done;
  endtask

  task automatic load_basic();
    wr(0, w(OP_LOAD, 8'h05));
    wr(1, w(OP_ADD,  8'h03));
    wr(2, w(OP_SUB,  8'h01));
  endtask

  initial begin
    int         lat, bcyc, errs, dcnt;
    logic       dafter;
    logic [7:0] last_res;

    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.len = '0;

    vecs[0].name = "basic";    vecs[0].nw = 3; vecs[0].len = 3;  vecs[0].res = 8'h07; vecs[0].lat = 8;
    vecs[0].prog[0] = w(OP_LOAD, 8'h05); vecs[0].prog[1] = w(OP_ADD, 8'h03); vecs[0].prog[2] = w(OP_SUB, 8'h01);
    vecs[1].name = "logic";    vecs[1].nw = 4; vecs[1].len = 4;  vecs[1].res = 8'h73; vecs[1].lat = 10;
    vecs[1].prog[0] = w(OP_LOAD, 8'h0F); vecs[1].prog[1] = w(OP_AND, 8'h3C);
    vecs[1].prog[2] = w(OP_OR, 8'h80);   vecs[1].prog[3] = w(OP_XOR, 8'hFF);
    vecs[2].name = "single";   vecs[2].nw = 1; vecs[2].len = 1;  vecs[2].res = 8'hAA; vecs[2].lat = 4;
    vecs[2].prog[0] = w(OP_LOAD, 8'hAA);
    vecs[3].name = "short";    vecs[3].nw = 3; vecs[3].len = 2;  vecs[3].res = 8'h08; vecs[3].lat = 6;
    vecs[3].prog[0] = w(OP_LOAD, 8'h05); vecs[3].prog[1] = w(OP_ADD, 8'h03); vecs[3].prog[2] = w(OP_SUB, 8'h01);
    vecs[4].name = "sub_wrap"; vecs[4].nw = 2; vecs[4].len = 2;  vecs[4].res = 8'hF0; vecs[4].lat = 6;
    vecs[4].prog[0] = w(OP_LOAD, 8'h10); vecs[4].prog[1] = w(OP_SUB, 8'h20);
    vecs[5].name = "full";     vecs[5].nw = 16; vecs[5].len = 16; vecs[5].res = 8'h0F; vecs[5].lat = 34;
    vecs[5].prog[0] = w(OP_LOAD, 8'h00);
    for (int i = 1; i < 16; i++) vecs[5].prog[i] = w(OP_ADD, 8'h01);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_opcode", bus.alu_opcode, 4'hF);
    chk("rst_alu_a",  bus.alu_a, 8'h00);
    chk("rst_busy",   bus.busy, 1'b0);
    chk("rst_done",   bus.done, 1'b0);
    chk("rst_pc",     bus.pc, 0);
    chk("rst_result", bus.result, 8'h00);
    chk("rst_valid",  bus.result_valid, 1'b0);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].nw; i++) wr(AW'(i), vecs[v].prog[i]);
      run_prog((AW+1)'(vecs[v].len), 1'b0, '0, '0, lat, bcyc, dafter);
      chk({vecs[v].name, "_latency"}, lat, vecs[v].lat);
      chk({vecs[v].name, "_busy"}, bcyc, vecs[v].lat - 1);
      chk({vecs[v].name, "_result"}, bus.result, vecs[v].res);
      chk({vecs[v].name, "_valid"}, bus.result_valid, 1'b1);
      chk({vecs[v].name, "_done_width"}, dafter, 1'b0);
      errs = (pc_trace.size() == 2 * vecs[v].len) ? 0 : 1;
      for (int i = 0; i < pc_trace.size() && i < 2 * vecs[v].len; i++)
        if (pc_trace[i] != AW'(i / 2)) errs++;
      chk({vecs[v].name, "_pc_trace"}, errs, 0);
    end
    last_res = vecs[5].res;

    // len == 0: immediate done, nothing else changes.
    @(negedge clk); bus.start = 1'b1; bus.len = '0;
    @(posedge clk); #1; bus.start = 1'b0;
    chk("len0_done", bus.done, 1'b1);
    chk("len0_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    chk("len0_done_width", bus.done, 1'b0);
    chk("len0_busy_after", bus.busy, 1'b0);
    chk("len0_result", bus.result, last_res);
    chk("len0_valid", bus.result_valid, 1'b1);

    // Write and start ignored while busy.
    load_basic();
    @(negedge clk); bus.start = 1'b1; bus.len = 5'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = 4'd1; bus.prog_data = w(OP_ADD, 8'h50);
    bus.start = 1'b1; bus.len = 5'd1;
    @(posedge clk); #1; bus.prog_we = 1'b0; bus.start = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus.done) dcnt++;
      @(posedge clk); #1;
    end
    chk("lock_done_count", dcnt, 1);
    chk("lock_result", bus.result, 8'h07);
    run_prog(5'd3, 1'b0, '0, '0, lat, bcyc, dafter);
    chk("lock_rerun_result", bus.result, 8'h07);

    // Write on the start edge is visible to the first instruction.
    run_prog(5'd1, 1'b1, 4'd0, w(OP_LOAD, 8'h22), lat, bcyc, dafter);
    chk("wr_start_result", bus.result, 8'h22);
    chk("wr_start_latency", lat, 4);

    // Reset mid-run at pc == 1.
    wr(0, w(OP_LOAD, 8'h05));
    @(negedge clk); bus.start = 1'b1; bus.len = 5'd3;
    @(posedge clk); #1; bus.start = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.busy && bus.pc == 4'd1) break;
      @(posedge clk); #1;
    end
    chk("abort_reached_pc1", bus.pc, 1);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_opcode", bus.alu_opcode, 4'hF);
    chk("abort_pc", bus.pc, 0);
    chk("abort_valid", bus.result_valid, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) dcnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", dcnt, 0);
    chk("abort_valid_after", bus.result_valid, 1'b0);
    run_prog(5'd3, 1'b0, '0, '0, lat, bcyc, dafter);
    chk("abort_rerun_result", bus.result, 8'h07);
    chk("abort_rerun_valid", bus.result_valid, 1'b1);
    chk("abort_rerun_latency", lat, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
